// File: rtl/intersection_controller.sv
`default_nettype none
// ============================================================================
// Module   : intersection_controller
// Purpose  : Sequences the main-road head, side-road head and pedestrian WALK
//            lamp for a single intersection. Main road rests in green; side
//            vehicles and pedestrians are arbitrated for the shared crossing.
//            Phase timing is counted in external 'tick' pulses.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high
//            tick       - timebase enable, one clk wide
//            side_req   - side-road vehicle detector (level or pulse)
//            ped_req    - pedestrian button (level or pulse)
//            night_mode - flashing-mode request (FLASH_MODE_EN builds only)
//            main_rgy   - main head {R,Y,G}, registered
//            side_rgy   - side head {R,Y,G}, registered
//            walk       - pedestrian WALK lamp, registered
//            ped_ack    - one-clk pulse on entry to the walk phase
//            state_o    - current FSM state encoding
// Options  : define FLASH_MODE_EN to add night_mode and the FLASH state.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_controller #(
  parameter int CW         = 8,
  parameter int GREEN_MAIN = 15,
  parameter int GREEN_SIDE = 10,
  parameter int YELLOW     = 2,
  parameter int ALL_RED    = 1,
  parameter int WALK       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
`ifdef FLASH_MODE_EN
  input  logic       night_mode,
`endif
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  // State encodings
  localparam logic [2:0] c_st_main_g = 3'd0;
  localparam logic [2:0] c_st_main_y = 3'd1;
  localparam logic [2:0] c_st_clr_a  = 3'd2;
  localparam logic [2:0] c_st_side_g = 3'd3;
  localparam logic [2:0] c_st_side_y = 3'd4;
  localparam logic [2:0] c_st_clr_b  = 3'd5;
  localparam logic [2:0] c_st_ped    = 3'd6;
  localparam logic [2:0] c_st_flash  = 3'd7;

  // Timer reload values: a phase of DUR ticks starts at DUR-1
  localparam logic [CW-1:0] c_ld_green_main = CW'(GREEN_MAIN - 1);
  localparam logic [CW-1:0] c_ld_green_side = CW'(GREEN_SIDE - 1);
  localparam logic [CW-1:0] c_ld_yellow     = CW'(YELLOW - 1);
  localparam logic [CW-1:0] c_ld_all_red    = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] c_ld_walk       = CW'(WALK - 1);
  localparam logic [CW-1:0] c_tmr_one       = CW'(1);

  localparam logic [2:0] c_lamp_r   = 3'b100;
  localparam logic [2:0] c_lamp_y   = 3'b010;
  localparam logic [2:0] c_lamp_g   = 3'b001;
  localparam logic [2:0] c_lamp_off = 3'b000;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] w_timer_nxt;
  logic          r_side_pend;
  logic          r_ped_pend;
  logic          r_last_ped;     // 1: pedestrians were served last, 0: side road
  logic          w_expire;
  logic          w_enter;
  logic          w_enter_side;
  logic          w_enter_ped;
  logic          w_serve_ped;
  logic          w_night;
  logic [2:0]    w_main_nxt;
  logic [2:0]    w_side_nxt;
  logic          w_walk_nxt;
  logic          w_ack_nxt;

`ifdef FLASH_MODE_EN
  logic          r_flash_on;
  logic          w_flash_on_nxt;
  assign w_night = night_mode;
`else
  assign w_night = 1'b0;
`endif

  assign w_expire     = (r_timer == '0) && tick;
  assign w_enter      = (w_state_nxt != r_state);
  assign w_enter_side = w_enter && (w_state_nxt == c_st_side_g);
  assign w_enter_ped  = w_enter && (w_state_nxt == c_st_ped);
  assign state_o      = r_state;

  // Both pending: alternate away from whoever was served last.
  // Nothing pending falls through to the side road.
  assign w_serve_ped  = r_ped_pend && (!r_side_pend || !r_last_ped);

  // --------------------------------------------------------------------------
  // State register, timer, pending flags and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_clr_b;
      r_timer     <= c_ld_all_red;
      r_side_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_last_ped  <= 1'b0;
      main_rgy    <= c_lamp_r;
      side_rgy    <= c_lamp_r;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
`ifdef FLASH_MODE_EN
      r_flash_on  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      // A request in the same clk as the clear keeps the flag set
      r_side_pend <= side_req | (r_side_pend & ~w_enter_side);
      r_ped_pend  <= ped_req | (r_ped_pend & ~w_enter_ped);
      if (w_enter_side) begin
        r_last_ped <= 1'b0;
      end else if (w_enter_ped) begin
        r_last_ped <= 1'b1;
      end
      main_rgy    <= w_main_nxt;
      side_rgy    <= w_side_nxt;
      walk        <= w_walk_nxt;
      ped_ack     <= w_ack_nxt;
`ifdef FLASH_MODE_EN
      r_flash_on  <= w_flash_on_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Holds with the timer parked at 0 until a request is pending
      c_st_main_g: if (w_expire && (r_side_pend || r_ped_pend)) w_state_nxt = c_st_main_y;
      c_st_main_y: if (w_expire) w_state_nxt = c_st_clr_a;
      c_st_clr_a: begin
        if (w_expire) begin
          if (w_night) begin
            w_state_nxt = c_st_flash;
          end else if (w_serve_ped) begin
            w_state_nxt = c_st_ped;
          end else begin
            w_state_nxt = c_st_side_g;
          end
        end
      end
      c_st_side_g: if (w_expire) w_state_nxt = c_st_side_y;
      c_st_side_y: if (w_expire) w_state_nxt = c_st_clr_b;
      c_st_ped:    if (w_expire) w_state_nxt = c_st_clr_b;
      c_st_clr_b:  if (w_expire) w_state_nxt = w_night ? c_st_flash : c_st_main_g;
`ifdef FLASH_MODE_EN
      c_st_flash:  if (tick && !night_mode) w_state_nxt = c_st_clr_b;
`endif
      // Reserved encoding recovers through the all-red clearance
      default:     w_state_nxt = c_st_clr_b;
    endcase
  end

  // Timer: reload on every state entry, otherwise count ticks down to zero.
  // The tick in the entry cycle is deliberately not counted.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_enter) begin
      case (w_state_nxt)
        c_st_main_g: w_timer_nxt = c_ld_green_main;
        c_st_main_y: w_timer_nxt = c_ld_yellow;
        c_st_clr_a:  w_timer_nxt = c_ld_all_red;
        c_st_side_g: w_timer_nxt = c_ld_green_side;
        c_st_side_y: w_timer_nxt = c_ld_yellow;
        c_st_clr_b:  w_timer_nxt = c_ld_all_red;
        c_st_ped:    w_timer_nxt = c_ld_walk;
        default:     w_timer_nxt = '0;
      endcase
    end else if (tick && (r_timer != '0)) begin
      w_timer_nxt = r_timer - c_tmr_one;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from next state so lamps change on the same edge as state
  // --------------------------------------------------------------------------
  always_comb begin
    w_main_nxt = c_lamp_r;
    w_side_nxt = c_lamp_r;
    w_walk_nxt = 1'b0;
    w_ack_nxt  = 1'b0;
`ifdef FLASH_MODE_EN
    w_flash_on_nxt = 1'b0;
`endif
    case (w_state_nxt)
      c_st_main_g: w_main_nxt = c_lamp_g;
      c_st_main_y: w_main_nxt = c_lamp_y;
      c_st_side_g: w_side_nxt = c_lamp_g;
      c_st_side_y: w_side_nxt = c_lamp_y;
      c_st_ped: begin
        w_walk_nxt = 1'b1;
        w_ack_nxt  = (r_state != c_st_ped);
      end
`ifdef FLASH_MODE_EN
      c_st_flash: begin
        // Lamps start lit on entry, then toggle on each tick
        if (r_state != c_st_flash) begin
          w_flash_on_nxt = 1'b1;
        end else begin
          w_flash_on_nxt = tick ? ~r_flash_on : r_flash_on;
        end
        w_main_nxt = w_flash_on_nxt ? c_lamp_y : c_lamp_off;
        w_side_nxt = w_flash_on_nxt ? c_lamp_r : c_lamp_off;
      end
`endif
      default: begin
        w_main_nxt = c_lamp_r;
        w_side_nxt = c_lamp_r;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_intersection_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_controller
// Purpose  : Self-checking bench for intersection_controller. Each scenario
//            pushes the expected per-clock {state, main, side, walk, ack}
//            trace into a scoreboard queue, then drives stimulus and pops one
//            entry per clock to compare. A monitor checks lamp safety rules
//            on every falling edge.
// Options  : FLASH_MODE_EN adds the night_mode port and a flash scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_controller;

  localparam int CW = 8;
  localparam int GM = 4;
  localparam int GS = 3;
  localparam int YL = 2;
  localparam int AR = 1;
  localparam int WK = 3;

  localparam logic [2:0] S_MG = 3'd0;
  localparam logic [2:0] S_MY = 3'd1;
  localparam logic [2:0] S_CA = 3'd2;
  localparam logic [2:0] S_SG = 3'd3;
  localparam logic [2:0] S_SY = 3'd4;
  localparam logic [2:0] S_CB = 3'd5;
  localparam logic [2:0] S_PW = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
`ifdef FLASH_MODE_EN
  logic       night_mode = 1'b0;
`endif
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic [2:0] state_o;
  logic       walk;
  logic       ped_ack;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  intersection_controller #(
    .CW(CW), .GREEN_MAIN(GM), .GREEN_SIDE(GS), .YELLOW(YL), .ALL_RED(AR), .WALK(WK)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .side_req(side_req),
    .ped_req(ped_req),
`ifdef FLASH_MODE_EN
    .night_mode(night_mode),
`endif
    .main_rgy(main_rgy),
    .side_rgy(side_rgy),
    .walk(walk),
    .ped_ack(ped_ack),
    .state_o(state_o)
  );

  // Expected observable vector for a normal (non-flash) state
  function automatic logic [10:0] exp_vec(input logic [2:0] st, input logic ack);
    logic [2:0] m;
    logic [2:0] s;
    m = (st == S_MG) ? 3'b001 : (st == S_MY) ? 3'b010 : 3'b100;
    s = (st == S_SG) ? 3'b001 : (st == S_SY) ? 3'b010 : 3'b100;
    return {st, m, s, (st == S_PW), ack};
  endfunction

  task automatic push_phase(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_vec(st, (st == S_PW) && (i == 0)));
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick = 1'b1; side_req = 1'b0; ped_req = 1'b0;
`ifdef FLASH_MODE_EN
    night_mode = 1'b0;
`endif
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Safety: never both heads showing G/Y; WALK only with both heads red
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (((main_rgy[1:0] != 2'b00) && (side_rgy[1:0] != 2'b00)) ||
          (walk && ((main_rgy != 3'b100) || (side_rgy != 3'b100)))) begin
        n_err++;
        $display("FAIL safety t=%0t main=%b side=%b walk=%b required: no conflict", $time, main_rgy, side_rgy, walk);
      end
    end
  end

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b1; tick = 1'b1; side_req = 1'b1; ped_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {state_o, main_rgy, side_rgy, walk, ped_ack};
    n_cmp++;
    if (got !== exp_vec(S_CB, 1'b0)) begin
      n_err++;
      $display("FAIL reset_state got=%b required=%b", got, exp_vec(S_CB, 1'b0));
    end
    side_req = 1'b0; ped_req = 1'b0; reset = 1'b0;
  endtask

  // Requests held during reset must not survive: main stays green
  task automatic test_idle();
    logic [10:0] got, want;
    int n;
    push_phase(S_MG, 50);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL idle k=%0d got=%b required=%b", k, got, want);
      end
    end
  endtask

  task automatic test_side();
    logic [10:0] got, want;
    int n;
    apply_reset();
    push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR);
    push_phase(S_SG, GS); push_phase(S_SY, YL); push_phase(S_CB, AR);
    push_phase(S_MG, 8);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL side k=%0d got=%b required=%b", k, got, want);
      end
      side_req = (k == 1);
    end
  endtask

  task automatic test_both();
    logic [10:0] got, want;
    int n;
    apply_reset();
    push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR);
    push_phase(S_PW, WK); push_phase(S_CB, AR);
    push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR);
    push_phase(S_SG, GS); push_phase(S_SY, YL); push_phase(S_CB, AR);
    push_phase(S_MG, 6);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL both k=%0d got=%b required=%b", k, got, want);
      end
      side_req = (k == 1);
      ped_req  = (k == 1);
    end
  endtask

  task automatic test_ped_held();
    logic [10:0] got, want;
    int n;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR);
      push_phase(S_PW, WK); push_phase(S_CB, AR);
    end
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ped_held k=%0d got=%b required=%b", k, got, want);
      end
      ped_req = 1'b1;
    end
    ped_req = 1'b0;
  endtask

  // One tick every 4 clks: each phase spans 4*DUR clks
  task automatic test_slow_tick();
    logic [10:0] got, want;
    int n;
    apply_reset();
    push_phase(S_MG, 4 * GM); push_phase(S_MY, 4 * YL); push_phase(S_CA, 4 * AR);
    push_phase(S_SG, 4 * GS); push_phase(S_SY, 4 * YL); push_phase(S_CB, 4 * AR);
    push_phase(S_MG, 4);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL slow_tick k=%0d got=%b required=%b", k, got, want);
      end
      side_req = (k == 1);
      tick     = (((k + 1) % 4) == 1);
    end
    tick = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, want;
    int n;
    apply_reset();
    push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR); push_phase(S_SG, 2);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL pre_reset k=%0d got=%b required=%b", k, got, want);
      end
      side_req = (k == 1);
      ped_req  = (k == n - 1);
    end
    ped_req = 1'b0;
    reset = 1'b1;
    #2;
    got = {state_o, main_rgy, side_rgy, walk, ped_ack};
    n_cmp++;
    if (got !== exp_vec(S_CB, 1'b0)) begin
      n_err++;
      $display("FAIL async_reset got=%b required=%b", got, exp_vec(S_CB, 1'b0));
    end
    @(posedge clk); #1;
    got = {state_o, main_rgy, side_rgy, walk, ped_ack};
    n_cmp++;
    if (got !== exp_vec(S_CB, 1'b0)) begin
      n_err++;
      $display("FAIL reset_hold got=%b required=%b", got, exp_vec(S_CB, 1'b0));
    end
    reset = 1'b0;
    // Pending pedestrian request was dropped: main must rest in green
    push_phase(S_MG, 10);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL post_reset k=%0d got=%b required=%b", k, got, want);
      end
    end
  endtask

`ifdef FLASH_MODE_EN
  task automatic test_flash();
    logic [10:0] got, want;
    int n;
    apply_reset();
    reset = 1'b1; night_mode = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++)
      sb_q.push_back((i % 2 == 0) ? {3'd7, 3'b010, 3'b100, 2'b00} : {3'd7, 3'b000, 3'b000, 2'b00});
    push_phase(S_CB, AR);
    push_phase(S_MG, GM); push_phase(S_MY, YL); push_phase(S_CA, AR); push_phase(S_SG, GS);
    n = sb_q.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = sb_q.pop_front();
      got  = {state_o, main_rgy, side_rgy, walk, ped_ack};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL flash k=%0d got=%b required=%b", k, got, want);
      end
      side_req   = (k == 2);
      night_mode = (k < 4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_side();
    test_both();
    test_ped_held();
    test_slow_tick();
    test_reset_mid();
`ifdef FLASH_MODE_EN
    test_flash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences two traffic-light heads (main road, side road) and a pedestrian WALK signal for one intersection.
- Arbitrates the shared intersection between side-road vehicle requests and pedestrian requests.
- Main road rests in green; timing is counted in `tick` pulses from an external timebase, so the block runs on the system clock.

Parameters:
- CW, 8: width of the phase timer.
- GREEN_MAIN, 15: minimum main green, in ticks.
- GREEN_SIDE, 10: side green, in ticks.
- YELLOW, 2: yellow duration for either road, in ticks.
- ALL_RED, 1: all-red clearance, in ticks.
- WALK, 8: pedestrian walk phase, in ticks.
- Every duration must satisfy 1 <= value <= 2^CW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- tick  in  1  timebase enable, one clk wide; the timer advances only when tick=1.
- side_req  in  1  side-road vehicle detector, level or pulse.
- ped_req  in  1  pedestrian button, level or pulse.
- main_rgy  out  3  main head {R,Y,G}, one-hot, registered.
- side_rgy  out  3  side head {R,Y,G}, one-hot, registered.
- walk  out  1  pedestrian WALK lamp, registered.
- ped_ack  out  1  one-clk pulse on entry to PED_WALK.
- state_o  out  3  current FSM state encoding.

Behaviour:

States and encodings: MAIN_G=0, MAIN_Y=1, CLR_A=2, SIDE_G=3, SIDE_Y=4, CLR_B=5, PED_WALK=6. 7 is reserved.

Reset (asynchronous):
- state=CLR_B, timer=ALL_RED-1.
- side_pend=0, ped_pend=0, last_srv=SIDE.
- main_rgy=3'b100, side_rgy=3'b100, walk=0, ped_ack=0.

Timer:
- Loaded with DUR-1 on the clk that enters a state, where DUR is that state's duration.
- Decrements on each tick while nonzero.
- Expiry = (timer==0 && tick).
- Each state therefore lasts exactly DUR tick pulses. The tick arriving in the entry cycle is not counted.

Pending flags:
- side_pend is set on any clk with side_req=1; ped_pend is set on any clk with ped_req=1. Both are sticky.
- side_pend is cleared on entry to SIDE_G; ped_pend is cleared on entry to PED_WALK.
- If a request is asserted in the same clk as the clear, set wins and the flag stays 1.

Transitions (all taken only on expiry):
- MAIN_G -> MAIN_Y, only if side_pend|ped_pend. Otherwise hold MAIN_G with timer held at 0; when a request arrives, leave on the next tick.
- MAIN_Y -> CLR_A.
- CLR_A -> PED_WALK or SIDE_G, chosen by the arbiter below. If no flag is pending, go to SIDE_G. This is unreachable by construction but must be defined.
- SIDE_G -> SIDE_Y -> CLR_B.
- PED_WALK -> CLR_B.
- CLR_B -> MAIN_G.

Arbiter (evaluated at CLR_A expiry):
- Only one flag pending: serve it.
- Both pending: serve the type not equal to last_srv.
- last_srv updates on entry to SIDE_G or PED_WALK.

Output decode:
- main_rgy: G in MAIN_G, Y in MAIN_Y, R in all other states.
- side_rgy: G in SIDE_G, Y in SIDE_Y, R in all other states.
- walk=1 only in PED_WALK.
- Outputs are registered from next-state: they change in the same clk edge as state_o, with no extra cycle.

Safety:
- At no time may main_rgy and side_rgy both be non-R.
- walk=1 implies both heads are R.
- The reserved encoding 7 recovers to CLR_B with all-red outputs.

Reset mid-phase: reset forces the reset values immediately, regardless of current state, and drops any pending requests.

Optional Feature:

FLASH_MODE_EN
- Adds input port night_mode (1 bit) and state FLASH=7.
- Entry: when night_mode=1 at expiry of CLR_A or CLR_B, enter FLASH instead of the normal next state.
- In FLASH:
  - main_rgy alternates 3'b010/3'b000 on each tick, starting at 3'b010.
  - side_rgy alternates 3'b100/3'b000 in phase with main.
  - walk=0.
  - Requests still latch into the pending flags.
- Exit: on the first tick with night_mode=0, go to CLR_B with all-red, then resume normal sequencing.
- Without the macro: no night_mode port; encoding 7 stays reserved and recovers to CLR_B.

Test Plan:
Common setup: tick=1 every clk. Parameters GREEN_MAIN=4, GREEN_SIDE=3, YELLOW=2, ALL_RED=1, WALK=3.

1. Release reset, no requests -> CLR_B for 1 clk, then MAIN_G; main_rgy=3'b001 held for 50 clks; side_rgy=3'b100 throughout.
2. side_req pulsed 1 clk at clk 2 after reset -> MAIN_G lasts 4 ticks, MAIN_Y 2, CLR_A 1, SIDE_G 3, SIDE_Y 2, CLR_B 1, then MAIN_G; side_pend=0 after SIDE_G entry.
3. side_req and ped_req asserted in the same clk -> PED_WALK served first (walk=1 for 3 clks, ped_ack pulses once); the next cycle serves SIDE_G.
4. ped_req held high continuously -> PED_WALK repeats each cycle with a full MAIN_G minimum of 4 ticks between WALK phases; ped_ack exactly once per WALK phase.
5. tick asserted once every 4 clks, side request -> SIDE_G lasts exactly 12 clks.
6. Assert reset during SIDE_G -> next sample main_rgy=side_rgy=3'b100, walk=0, state_o=5, flags=0. Under FLASH_MODE_EN: night_mode=1 -> FLASH entered after the next CLR_x, main_rgy toggling 3'b010/3'b000 each tick.

Throughout all scenarios: a bench assertion checks the safety invariants every clk.
